// File: rtl/ssram_ctrl_if.sv
// ssram_ctrl_if: request/response bus between a core and the SSRAM controller.
// Signals: data_req/we/be/addr/wdata (master->slave), data_gnt/rvalid/rdata/err (slave->master).
interface ssram_ctrl_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );
  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/ssram_ctrl.sv
// ssram_ctrl: single-port SSRAM macro controller with read-retry on unsettled FLAG.
// Ports: CLK, rst_n (sync active-low); bus (slave side of ssram_ctrl_if);
// cfg_en/cfg_mode pass through to EN/MODE; busy; macro pins CEN, WEN, BRS, D, Q, FLAG.
module ssram_ctrl #(
  parameter int RD_LAT    = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  ssram_ctrl_if.slave bus,
  input  logic [11:0] cfg_en,
  input  logic        cfg_mode,
  output logic        busy,
  output logic        CEN,
  output logic        WEN,
  output logic [7:0]  BRS,
  output logic [31:0] D,
  output logic [11:0] EN,
  output logic        MODE,
  input  logic [31:0] Q,
  input  logic        FLAG
);
  typedef enum logic [1:0] {IDLE, WR, RD, RETRY} state_t;
  state_t      state, next;
  logic [3:0]  be_q;
  logic [7:0]  idx_q;
  logic [31:0] wdata_q, rdata_q;
  logic [5:0]  lat_cnt;
  logic [2:0]  retry_cnt;
  logic        rvalid_q, err_q, gnt, full_wr, retry_more;
  logic        unused_addr;
  assign unused_addr = ^{bus.data_addr[31:10], bus.data_addr[1:0]};
  assign gnt        = bus.data_req && state == IDLE;
  assign full_wr    = be_q == 4'hF;
  assign retry_more = FLAG && retry_cnt < 3'(MAX_RETRY);
  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid_q;
  assign bus.data_rdata  = rdata_q;
  assign bus.data_err    = err_q;
  assign busy = state != IDLE;
  assign CEN  = !(state == RD || (state == WR && full_wr));
  assign WEN  = !(state == WR && full_wr);
  assign BRS  = idx_q;
  assign D    = wdata_q;
  assign EN   = cfg_en;
  assign MODE = cfg_mode;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = gnt ? (bus.data_we ? WR : RD) : IDLE;
      WR:      next = IDLE;
      RD:      next = lat_cnt != 0 ? RD : (retry_more ? RETRY : IDLE);
      default: next = RD;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state     <= IDLE;
      be_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      lat_cnt   <= '0;
      retry_cnt <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state    <= next;
      rvalid_q <= 1'b0;
      case (state)
        IDLE: if (gnt) begin
          be_q      <= bus.data_be;
          idx_q     <= bus.data_addr[9:2];
          wdata_q   <= bus.data_wdata;
          retry_cnt <= '0;
          lat_cnt   <= 6'(RD_LAT - 1);
        end
        WR: begin
          rvalid_q <= 1'b1;
          err_q    <= !full_wr;
          rdata_q  <= '0;
        end
        RD: if (lat_cnt != 0) lat_cnt <= lat_cnt - 6'd1;
          else if (retry_more) retry_cnt <= retry_cnt + 3'd1;
          else begin
            rdata_q  <= Q;
            err_q    <= FLAG;
            rvalid_q <= 1'b1;
          end
        default: lat_cnt <= 6'(RD_LAT - 1);
      endcase
    end
  end
endmodule

// File: tb/tb_ssram_ctrl.sv
// tb_ssram_ctrl: directed self-checking bench for ssram_ctrl (RD_LAT=8, MAX_RETRY=2).
module tb_ssram_ctrl;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cfg_en = 12'hA5C;
  logic        cfg_mode = 1'b1;
  logic        busy, CEN, WEN, MODE;
  logic [7:0]  BRS;
  logic [31:0] D;
  logic [11:0] EN;
  logic [31:0] Q = '0;
  logic        FLAG = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  ssram_ctrl_if bus();
  ssram_ctrl #(.RD_LAT(8), .MAX_RETRY(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .bus(bus), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .busy(busy), .CEN(CEN), .WEN(WEN), .BRS(BRS), .D(D), .EN(EN), .MODE(MODE),
    .Q(Q), .FLAG(FLAG)
  );
  always #5 CLK = ~CLK;
  task automatic cycle();
    @(posedge CLK);
    #2;
  endtask
  task automatic req(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    bus.data_req = 1'b1;
    bus.data_we = we;
    bus.data_be = be;
    bus.data_addr = addr;
    bus.data_wdata = wd;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_req = 1'b0;
    cycle();
    cycle();
    #1;
    n_cmp++;
    if ({CEN, WEN, BRS, D, busy} !== {1'b1, 1'b1, 8'h00, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_pins got CEN=%b WEN=%b BRS=%h D=%h busy=%b want 1 1 00 0 0", CEN, WEN, BRS, D, busy);
    end
    n_cmp++;
    if ({bus.data_rvalid, bus.data_rdata, bus.data_err} !== {1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_resp got rvalid=%b rdata=%h err=%b want 0 0 0", bus.data_rvalid, bus.data_rdata, bus.data_err);
    end
    n_cmp++;
    if (EN !== 12'hA5C || MODE !== 1'b1) begin
      n_bad++;
      $display("FAIL passthru got EN=%h MODE=%b want a5c 1", EN, MODE);
    end
    cfg_en = 12'h3F0;
    cfg_mode = 1'b0;
    #1;
    n_cmp++;
    if (EN !== 12'h3F0 || MODE !== 1'b0) begin
      n_bad++;
      $display("FAIL passthru2 got EN=%h MODE=%b want 3f0 0", EN, MODE);
    end
    n_cmp++;
    if (bus.data_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL gnt_idle_noreq got %b want 0", bus.data_gnt);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_write_full();
    cycle();
    req(1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
    n_cmp++;
    if (bus.data_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_gnt got %b want 1", bus.data_gnt);
    end
    cycle();
    bus.data_req = 1'b0;
    #1;
    n_cmp++;
    if ({CEN, WEN, BRS, D, busy} !== {1'b0, 1'b0, 8'h04, 32'hDEADBEEF, 1'b1}) begin
      n_bad++;
      $display("FAIL wr_pins got CEN=%b WEN=%b BRS=%h D=%h busy=%b want 0 0 04 deadbeef 1", CEN, WEN, BRS, D, busy);
    end
    cycle();
    #1;
    n_cmp++;
    if ({bus.data_rvalid, bus.data_err, bus.data_rdata, CEN, WEN, busy} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h CEN=%b WEN=%b busy=%b want 1 0 0 1 1 0",
               bus.data_rvalid, bus.data_err, bus.data_rdata, CEN, WEN, busy);
    end
    cycle();
    #1;
    n_cmp++;
    if (bus.data_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_pulse_once got rvalid=%b want 0", bus.data_rvalid);
    end
  endtask
  // Issues one read; FLAG is held high for the first `fails` RD phases.
  task automatic test_read(input string name, input int fails, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] qv, input int exp_lat, input int exp_cen, input int exp_retry,
                           input logic exp_err, input logic [7:0] exp_brs);
    int n = 1, cen_low = 0, retries = 0, wen_bad = 0, brs_bad = 0;
    cycle();
    Q = qv;
    FLAG = fails > 0;
    req(1'b0, be, addr, 32'h0BAD_0BAD);
    n_cmp++;
    if (bus.data_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_gnt got %b want 1", name, bus.data_gnt);
    end
    do begin
      cycle();
      bus.data_req = 1'b0;
      n++;
      #1;
      if (CEN === 1'b0) begin
        cen_low++;
        if (WEN !== 1'b1) wen_bad++;
        if (BRS !== exp_brs) brs_bad++;
      end
      if (busy === 1'b1 && CEN === 1'b1) retries++;
      FLAG = retries < fails;
    end while (bus.data_rvalid !== 1'b1 && n < 200);
    n_cmp++;
    if (n !== exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", name, n, exp_lat);
    end
    n_cmp++;
    if (cen_low !== exp_cen || retries !== exp_retry) begin
      n_bad++;
      $display("FAIL %s_phases got cen_low=%0d retry=%0d want %0d %0d", name, cen_low, retries, exp_cen, exp_retry);
    end
    n_cmp++;
    if (wen_bad !== 0 || brs_bad !== 0) begin
      n_bad++;
      $display("FAIL %s_rd_pins got wen_bad=%0d brs_bad=%0d want 0 0", name, wen_bad, brs_bad);
    end
    n_cmp++;
    if (bus.data_rdata !== qv || bus.data_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s_data got rdata=%h err=%b want %h %b", name, bus.data_rdata, bus.data_err, qv, exp_err);
    end
    FLAG = 1'b0;
    Q = 32'h5555_AAAA;
    cycle();
    #1;
    n_cmp++;
    if (bus.data_rvalid !== 1'b0 || bus.data_rdata !== qv || bus.data_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s_hold got rvalid=%b rdata=%h err=%b want 0 %h %b", name, bus.data_rvalid, bus.data_rdata, bus.data_err, qv, exp_err);
    end
  endtask
  task automatic test_back_to_back();
    cycle();
    req(1'b1, 4'h3, 32'h0000_0008, 32'h1111_2222);
    n_cmp++;
    if (bus.data_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gnt1 got %b want 1", bus.data_gnt);
    end
    cycle();
    req(1'b1, 4'hF, 32'h0000_0020, 32'h3333_4444);
    n_cmp++;
    if ({CEN, WEN, bus.data_gnt, busy} !== {1'b1, 1'b1, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_partial_wr got CEN=%b WEN=%b gnt=%b busy=%b want 1 1 0 1", CEN, WEN, bus.data_gnt, busy);
    end
    cycle();
    #1;
    n_cmp++;
    if ({bus.data_rvalid, bus.data_err, bus.data_gnt} !== {1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_resp_gnt got rvalid=%b err=%b gnt=%b want 1 1 1", bus.data_rvalid, bus.data_err, bus.data_gnt);
    end
    cycle();
    bus.data_req = 1'b0;
    #1;
    n_cmp++;
    if ({CEN, WEN, BRS, D} !== {1'b0, 1'b0, 8'h08, 32'h3333_4444}) begin
      n_bad++;
      $display("FAIL b2b_wr2 got CEN=%b WEN=%b BRS=%h D=%h want 0 0 08 33334444", CEN, WEN, BRS, D);
    end
    cycle();
    #1;
    n_cmp++;
    if (bus.data_rvalid !== 1'b1 || bus.data_err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_resp2 got rvalid=%b err=%b want 1 0", bus.data_rvalid, bus.data_err);
    end
  endtask
  task automatic test_reset_mid_read();
    int rv = 0;
    cycle();
    req(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      bus.data_req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (CEN !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_pre got CEN=%b want 0", CEN);
    end
    cycle();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({CEN, busy, bus.data_rvalid} !== {1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid_abort got CEN=%b busy=%b rvalid=%b want 1 0 0", CEN, busy, bus.data_rvalid);
    end
    req(1'b1, 4'hF, 32'h0000_0044, 32'h7777_8888);
    n_cmp++;
    if (bus.data_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_regrant got %b want 1", bus.data_gnt);
    end
    cycle();
    bus.data_req = 1'b0;
    #1;
    if (bus.data_rvalid === 1'b1) rv++;
    cycle();
    #1;
    n_cmp++;
    if (rv !== 0 || bus.data_rvalid !== 1'b1 || bus.data_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_new_wr got early=%0d rvalid=%b err=%b want 0 1 0", rv, bus.data_rvalid, bus.data_err);
    end
  endtask
  initial begin
    bus.data_req = 1'b0;
    bus.data_we = 1'b0;
    bus.data_be = 4'h0;
    bus.data_addr = '0;
    bus.data_wdata = '0;
    test_reset();
    test_write_full();
    test_read("rd_ok", 0, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 10, 8, 0, 1'b0, 8'h04);
    test_read("rd_retry1", 1, 32'h1234_5FFF, 4'h0, 32'h1234_5678, 19, 16, 1, 1'b0, 8'hFF);
    test_read("rd_stuck", 3, 32'h0000_0400, 4'h1, 32'hCAFE_F00D, 28, 24, 2, 1'b1, 8'h00);
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
